// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage data-memory access controller:
// ext_op codes, FSM states, bus payload and lane helpers.
package mem_access_ctrl_pkg;

    localparam int unsigned XLEN            = 32;
    localparam int unsigned BE_W            = 4;
    localparam int unsigned OP_W            = 3;
    localparam int unsigned TIMEOUT_DEFAULT = 64;
    localparam int unsigned CNT_W_DEFAULT   = 7;

    localparam logic [OP_W-1:0] EXT_W  = 3'd0;
    localparam logic [OP_W-1:0] EXT_BU = 3'd1;
    localparam logic [OP_W-1:0] EXT_B  = 3'd2;
    localparam logic [OP_W-1:0] EXT_HU = 3'd3;
    localparam logic [OP_W-1:0] EXT_H  = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [BE_W-1:0] be;
        logic [XLEN-1:0] wdata;
    } bus_req_t;

    // Unknown op codes behave as full-word accesses.
    function automatic size_e op_size(input logic [OP_W-1:0] op);
        case (op)
            EXT_B, EXT_BU: op_size = SZ_BYTE;
            EXT_H, EXT_HU: op_size = SZ_HALF;
            default:       op_size = SZ_WORD;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [OP_W-1:0] op, input logic [1:0] addr_lo);
        case (op_size(op))
            SZ_BYTE: is_misaligned = 1'b0;
            SZ_HALF: is_misaligned = addr_lo[0];
            default: is_misaligned = (addr_lo != 2'b00);
        endcase
    endfunction

    function automatic logic [BE_W-1:0] byte_en(input logic [OP_W-1:0] op, input logic [1:0] addr_lo);
        case (op_size(op))
            SZ_BYTE: byte_en = 4'b0001 << addr_lo;
            SZ_HALF: byte_en = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] lane_wdata(input logic [OP_W-1:0] op, input logic [XLEN-1:0] wdata);
        case (op_size(op))
            SZ_BYTE: lane_wdata = {4{wdata[7:0]}};
            SZ_HALF: lane_wdata = {2{wdata[15:0]}};
            default: lane_wdata = wdata;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_ctrl_load_lane_ext.sv
// Combinational load lane select plus zero/sign extension of the bus read word.
module load_lane_ext
    import mem_access_ctrl_pkg::*;
(
    input  logic [1:0]      addr_lo_i,
    input  logic [OP_W-1:0] ext_op_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [XLEN-1:0] data_o
);

    logic [7:0]  byte_c;
    logic [15:0] half_c;

    always_comb begin
        byte_c = rdata_i[{addr_lo_i, 3'b000} +: 8];
        half_c = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (ext_op_i)
            EXT_B:   data_o = {{24{byte_c[7]}}, byte_c};
            EXT_BU:  data_o = {24'h00_0000, byte_c};
            EXT_H:   data_o = {{16{half_c[15]}}, half_c};
            EXT_HU:  data_o = {16'h0000, half_c};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer onto a req/ack data bus with pipeline stall.
// Define MEM_BUS_TIMEOUT_EN to enable the BUSY-state bus timeout (bus_err).
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter int unsigned CNT_W          = CNT_W_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            mem_valid,
    input  logic            mem_we,
    input  logic [OP_W-1:0] mem_ext_op,
    input  logic [XLEN-1:0] mem_addr,
    input  logic [XLEN-1:0] mem_wdata,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] load_data,
    output logic            exc_adel,
    output logic            exc_ades,
    output logic            bus_err,
    output logic            bus_req,
    output logic            bus_we,
    output logic [XLEN-1:0] bus_addr,
    output logic [BE_W-1:0] bus_be,
    output logic [XLEN-1:0] bus_wdata,
    input  logic [XLEN-1:0] bus_rdata,
    input  logic            bus_ack
);

    if ((64'(1) << CNT_W) <= 64'(TIMEOUT_CYCLES)) begin : g_cfg_check
        $error("mem_access_ctrl: CNT_W too narrow for TIMEOUT_CYCLES");
    end

    state_e          state_q;
    bus_req_t        req_q;
    logic [OP_W-1:0] ext_op_q;
    logic            bus_req_q;
    logic            done_q;
    logic [XLEN-1:0] load_data_q;
    logic [XLEN-1:0] ext_data;
    logic            idle_c;
    logic            misalign_c;
    logic            accept_c;

    load_lane_ext u_load_lane_ext (
        .addr_lo_i (req_q.addr[1:0]),
        .ext_op_i  (ext_op_q),
        .rdata_i   (bus_rdata),
        .data_o    (ext_data)
    );

    // Issue decode; reset gates every combinational response.
    always_comb begin
        idle_c     = reset && (state_q == S_IDLE) && mem_valid;
        misalign_c = is_misaligned(mem_ext_op, mem_addr[1:0]);
        accept_c   = idle_c && !misalign_c;
        exc_adel   = idle_c && misalign_c && !mem_we;
        exc_ades   = idle_c && misalign_c && mem_we;
        stall      = accept_c || (reset && (state_q == S_BUSY));
    end

`ifdef MEM_BUS_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q;
    logic             bus_err_q;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            req_q       <= '0;
            ext_op_q    <= EXT_W;
            bus_req_q   <= 1'b0;
            done_q      <= 1'b0;
            load_data_q <= '0;
`ifdef MEM_BUS_TIMEOUT_EN
            cnt_q       <= '0;
            bus_err_q   <= 1'b0;
`endif
        end else begin
            done_q    <= 1'b0;
`ifdef MEM_BUS_TIMEOUT_EN
            bus_err_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (accept_c) begin
                        req_q.we    <= mem_we;
                        req_q.addr  <= mem_addr;
                        req_q.be    <= byte_en(mem_ext_op, mem_addr[1:0]);
                        req_q.wdata <= lane_wdata(mem_ext_op, mem_wdata);
                        ext_op_q    <= mem_ext_op;
                        bus_req_q   <= 1'b1;
                        state_q     <= S_BUSY;
`ifdef MEM_BUS_TIMEOUT_EN
                        cnt_q       <= '0;
`endif
                    end
                end
                S_BUSY: begin
                    // An ack always wins over a timeout reached in the same cycle.
                    if (bus_ack) begin
                        if (!req_q.we) begin
                            load_data_q <= ext_data;
                        end
                        bus_req_q <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= S_DONE;
                    end
`ifdef MEM_BUS_TIMEOUT_EN
                    else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        load_data_q <= '0;
                        bus_req_q   <= 1'b0;
                        done_q      <= 1'b1;
                        bus_err_q   <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
`endif
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef MEM_BUS_TIMEOUT_EN
    assign bus_err = bus_err_q;
`else
    assign bus_err = 1'b0;
`endif

    assign done      = done_q;
    assign load_data = load_data_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = req_q.we;
    assign bus_addr  = {req_q.addr[XLEN-1:2], 2'b00};
    assign bus_be    = req_q.be;
    assign bus_wdata = req_q.wdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl.
module tb_mem_access_ctrl;
    import mem_access_ctrl_pkg::*;

    logic        clk;
    logic        reset;
    logic        mem_valid;
    logic        mem_we;
    logic [2:0]  mem_ext_op;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        stall;
    logic        done;
    logic [31:0] load_data;
    logic        exc_adel;
    logic        exc_ades;
    logic        bus_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    int n_checks;
    int n_errors;

    int          r_stall;
    int          r_done_cyc;
    logic        r_stable;
    logic        r_err;
    logic        r_we;
    logic [31:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [31:0] r_load;
    logic        seen_req;

    mem_access_ctrl #(
        .TIMEOUT_CYCLES (4),
        .CNT_W          (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_valid  (mem_valid),
        .mem_we     (mem_we),
        .mem_ext_op (mem_ext_op),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .stall      (stall),
        .done       (done),
        .load_data  (load_data),
        .exc_adel   (exc_adel),
        .exc_ades   (exc_ades),
        .bus_err    (bus_err),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_be     (bus_be),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .bus_ack    (bus_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drives one access and acts as the bus slave; ack_cyc is the BUSY cycle
    // (1-based) carrying bus_ack, 0 for never. Results land in the r_* vars.
    task automatic run_access(input logic we, input logic [2:0] op, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata, input int ack_cyc);
        int busy_n;
        busy_n     = 0;
        r_stall    = 0;
        r_done_cyc = 0;
        r_stable   = 1'b1;
        r_err      = 1'b0;
        r_we       = 1'b0;
        r_addr     = 32'h0;
        r_be       = 4'h0;
        r_wdata    = 32'h0;
        r_load     = 32'h0;
        @(negedge clk);
        mem_valid  = 1'b1;
        mem_we     = we;
        mem_ext_op = op;
        mem_addr   = addr;
        mem_wdata  = wdata;
        bus_ack    = 1'b0;
        bus_rdata  = 32'h0BAD_F00D;
        for (int c = 1; c <= 40; c++) begin
            #1;
            if (stall) r_stall++;
            if (done) begin
                r_done_cyc = c;
                r_err      = bus_err;
                r_load     = load_data;
                break;
            end
            if (bus_req) begin
                busy_n++;
                if (busy_n == 1) begin
                    r_we    = bus_we;
                    r_addr  = bus_addr;
                    r_be    = bus_be;
                    r_wdata = bus_wdata;
                end else if ({bus_we, bus_addr, bus_be, bus_wdata} !== {r_we, r_addr, r_be, r_wdata}) begin
                    r_stable = 1'b0;
                end
                bus_ack   = (busy_n == ack_cyc);
                bus_rdata = (busy_n == ack_cyc) ? rdata : 32'h0BAD_F00D;
            end else begin
                bus_ack = 1'b0;
            end
            @(negedge clk);
        end
        mem_valid = 1'b0;
        bus_ack   = 1'b0;
        check("done_seen", 32'(r_done_cyc != 0), 32'd1);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        reset      = 1'b0;
        mem_valid  = 1'b0;
        mem_we     = 1'b0;
        mem_ext_op = EXT_W;
        mem_addr   = 32'h0;
        mem_wdata  = 32'h0;
        bus_rdata  = 32'h0;
        bus_ack    = 1'b0;

        // Reset state, with a valid aligned request that must be ignored.
        repeat (3) @(negedge clk);
        mem_valid = 1'b1;
        #1;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_bus_err", 32'(bus_err), 32'd0);
        check("rst_load_data", load_data, 32'h0);
        check("rst_bus_fields", {bus_addr[27:0], bus_be}, 32'h0);
        check("rst_bus_wdata_we", {bus_wdata[30:0], bus_we}, 32'h0);
        mem_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // lb at ...03, immediate ack
        run_access(1'b0, EXT_B, 32'h1000_0003, 32'h0, 32'h80FF_1234, 1);
        check("lb_done_cycle", 32'(r_done_cyc), 32'd3);
        check("lb_stall_cycles", 32'(r_stall), 32'd2);
        check("lb_be", 32'(r_be), 32'h8);
        check("lb_addr", r_addr, 32'h1000_0000);
        check("lb_we", 32'(r_we), 32'd0);
        check("lb_load", r_load, 32'hFFFF_FF80);
        check("lb_bus_err", 32'(r_err), 32'd0);
        @(negedge clk);
        #1;
        check("lb_done_one_pulse", 32'(done), 32'd0);
        check("lb_idle_stall", 32'(stall), 32'd0);

        // lhu at ...02, ack in 5th BUSY cycle
        run_access(1'b0, EXT_HU, 32'h2000_0002, 32'h0, 32'hBEEF_0001, 5);
        check("lhu_stall_cycles", 32'(r_stall), 32'd6);
        check("lhu_done_cycle", 32'(r_done_cyc), 32'd7);
        check("lhu_stable", 32'(r_stable), 32'd1);
        check("lhu_be", 32'(r_be), 32'hC);
        check("lhu_load", r_load, 32'h0000_BEEF);

        // sb at ...01
        run_access(1'b1, EXT_B, 32'h3000_0001, 32'h1234_56AB, 32'hFFFF_FFFF, 2);
        check("sb_we", 32'(r_we), 32'd1);
        check("sb_be", 32'(r_be), 32'h2);
        check("sb_wdata", r_wdata, 32'hABAB_ABAB);
        check("sb_addr", r_addr, 32'h3000_0000);
        check("sb_stable", 32'(r_stable), 32'd1);
        @(negedge clk);
        #1;
        check("sb_load_kept", load_data, 32'h0000_BEEF);

        // lbu lane 2, lh lane 0, sw word
        run_access(1'b0, EXT_BU, 32'h7000_0006, 32'h0, 32'h12C3_0000, 1);
        check("lbu_load", r_load, 32'h0000_00C3);
        check("lbu_be", 32'(r_be), 32'h4);
        run_access(1'b0, EXT_H, 32'h7000_0000, 32'h0, 32'h1234_8001, 3);
        check("lh_load", r_load, 32'hFFFF_8001);
        check("lh_be", 32'(r_be), 32'h3);
        run_access(1'b1, EXT_W, 32'h7000_0004, 32'hDEAD_BEEF, 32'h0, 1);
        check("sw_be", 32'(r_be), 32'hF);
        check("sw_wdata", r_wdata, 32'hDEAD_BEEF);
        check("sw_addr", r_addr, 32'h7000_0004);
        @(negedge clk);
        #1;
        check("sw_load_kept", load_data, 32'hFFFF_8001);

        // Misaligned lw then sh: exceptions only, no bus traffic
        @(negedge clk);
        mem_valid  = 1'b1;
        mem_we     = 1'b0;
        mem_ext_op = EXT_W;
        mem_addr   = 32'h4000_0002;
        #1;
        check("lw_mis_adel", 32'(exc_adel), 32'd1);
        check("lw_mis_ades", 32'(exc_ades), 32'd0);
        check("lw_mis_stall", 32'(stall), 32'd0);
        seen_req = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
            if (bus_req || stall) seen_req = 1'b1;
        end
        check("lw_mis_no_req", 32'(seen_req), 32'd0);
        mem_we     = 1'b1;
        mem_ext_op = EXT_H;
        mem_addr   = 32'h4000_0001;
        #1;
        check("sh_mis_ades", 32'(exc_ades), 32'd1);
        check("sh_mis_adel", 32'(exc_adel), 32'd0);
        check("sh_mis_stall", 32'(stall), 32'd0);
        mem_valid = 1'b0;
        #1;
        check("mis_exc_clear", 32'(exc_ades), 32'd0);

`ifdef MEM_BUS_TIMEOUT_EN
        // Ack on the last allowed cycle beats the timeout
        run_access(1'b0, EXT_W, 32'h6000_0000, 32'h0, 32'h1111_2222, 4);
        check("to_ack4_err", 32'(r_err), 32'd0);
        check("to_ack4_load", r_load, 32'h1111_2222);
        run_access(1'b0, EXT_W, 32'h6000_0000, 32'h0, 32'h0, 0);
        check("to_err", 32'(r_err), 32'd1);
        check("to_load_zero", r_load, 32'h0);
        check("to_stall_cycles", 32'(r_stall), 32'd5);
        @(negedge clk);
        #1;
        check("to_err_one_pulse", 32'(bus_err), 32'd0);
`endif

        // Reset during BUSY abandons the access; a late ack is ignored
        @(negedge clk);
        mem_valid  = 1'b1;
        mem_we     = 1'b0;
        mem_ext_op = EXT_W;
        mem_addr   = 32'h5000_0000;
        @(negedge clk);
        #1;
        check("rbusy_req_on", 32'(bus_req), 32'd1);
        reset     = 1'b0;
        mem_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rbusy_req_off", 32'(bus_req), 32'd0);
        check("rbusy_stall_off", 32'(stall), 32'd0);
        @(negedge clk);
        reset     = 1'b1;
        bus_ack   = 1'b1;
        bus_rdata = 32'hCAFE_F00D;
        #1;
        check("rbusy_idle_stall", 32'(stall), 32'd0);
        @(negedge clk);
        bus_ack = 1'b0;
        #1;
        check("rbusy_late_ack_done", 32'(done), 32'd0);
        check("rbusy_late_ack_req", 32'(bus_req), 32'd0);
        check("rbusy_load_reset", load_data, 32'h0);
        @(negedge clk);
        #1;
        check("rbusy_no_done_later", 32'(done), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
